uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Buffered byte queue that sits directly upstream of the UART transmitter.
It accepts bytes from the CPU/MMIO side over a valid/ready handshake and stores them in order.
Its dequeue side drives the transmitter's data_in/data_in_valid/data_in_ready handshake, so software can post bursts without polling for each byte.
It is a first-word-fall-through FIFO with an occupancy count and a sticky overflow flag.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 8, number of entries; must be a power of 2 and at least 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk
enq_data  in  WIDTH  byte from the producer
enq_valid  in  1  producer offers enq_data
enq_ready  out  1  FIFO can accept a word (high when not full)
deq_data  out  WIDTH  head-of-queue word; connects to the transmitter's data_in
deq_valid  out  1  head word valid (high when not empty); connects to data_in_valid
deq_ready  in  1  consumer takes the head word; connects to data_in_ready
count  out  PTR_W+1  number of stored entries, 0..DEPTH
overflow  out  1  sticky flag: set when a write is attempted while full
overflow_clr  in  1  clears overflow

Behaviour:
- Handshake events:
  - enq_fire = enq_valid & enq_ready.
  - deq_fire = deq_valid & deq_ready.
  - Transfers occur only on the clk edge where the fire signal is high.
- Reset (reset_n low, asynchronous):
  - Read and write pointers go to 0; count=0, overflow=0.
  - Outputs during reset: enq_ready=1, deq_valid=0.
  - deq_data is don't-care while deq_valid=0; storage contents are not reset.
- Pointers:
  - Read and write pointers are PTR_W+1 bits wide (extra wrap bit).
  - empty = pointers equal.
  - full = low PTR_W bits equal and wrap bits differ.
  - Each pointer increments by 1 on its fire signal and wraps naturally modulo 2*DEPTH.
- Status outputs:
  - enq_ready = !full and deq_valid = !empty. Both are derived only from registered state, with no combinational path from enq_valid or deq_ready.
  - count = wr_ptr - rd_ptr, computed modulo 2^(PTR_W+1). It equals the registered occupancy.
- Data path:
  - FWFT: deq_data = mem[rd_ptr[PTR_W-1:0]] (combinational read).
  - Latency: a word enqueued on edge N is visible with deq_valid=1 after edge N. Empty-to-output latency is 1 cycle; there is no same-cycle bypass.
  - A write stores enq_data into mem[wr_ptr[PTR_W-1:0]] on enq_fire.
- Simultaneous enq_fire and deq_fire:
  - Both pointers advance and count is unchanged.
  - When full, enq_ready=0, so no simultaneous write occurs. The write is refused even if a dequeue happens that cycle.
  - When empty, deq_valid=0, so no simultaneous read occurs.
- Overflow flag:
  - Set on any cycle with enq_valid=1 and full=1.
  - Cleared by overflow_clr=1.
  - If set and clear are both true in the same cycle, set wins.
  - The refused word is dropped; FIFO contents are unaffected.
- Stall safety: deq_data and deq_valid must remain stable while deq_valid=1 and deq_ready=0. The transmitter may hold data_in_ready low for a full frame (about 10 bit times).
- Reset mid-operation: all queued words are discarded immediately. A byte already latched by the transmitter is not this block's concern.

Decomposition:
- Shared package uart_pkg holds UART_DATA_W=8 and UART_TX_FIFO_DEPTH=8. The transmitter wrapper and this block use the same values.
- One natural sub-module: fifo_mem (DEPTH x WIDTH register array, one write port, one asynchronous read port, no reset).
- Pointer, flag and count logic stay in uart_tx_fifo.

Test Plan:
- Reset then idle -> count=0, enq_ready=1, deq_valid=0, overflow=0; hold for 5 cycles with no change.
- Enqueue 0x41 in one cycle with deq_ready=0 -> next cycle deq_valid=1, deq_data=0x41, count=1. Then deq_ready=1 for one cycle -> deq_valid=0, count=0.
- Fill with 0x00..0x07 (DEPTH=8) with deq_ready=0 -> count=8, enq_ready=0. Offer 0x08 -> overflow=1, count stays 8. Drain with deq_ready=1 -> outputs 0x00..0x07 in order, and 0x08 is never seen.
- Hold enq_valid=1 and deq_ready=1 for 20 cycles with data 0x10..0x23, starting empty -> count toggles 0->1, then stays 1. Output is 0x10..0x22 in order, so pointers wrap past 2*DEPTH without error.
- Full FIFO with enq_valid=1 and deq_ready=1 in the same cycle -> dequeue happens and the write is refused. Count goes to 7 and overflow=1.
- Assert overflow_clr alone -> overflow=0. Assert reset_n=0 asynchronously mid-drain with count=5 -> count=0 and deq_valid=0 without waiting for a clk edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART parameters. The transmitter wrapper and its byte FIFO both
// take their data width and queue depth from here.
package uart_pkg;
  localparam int UART_DATA_W        = 8;
  localparam int UART_TX_FIFO_DEPTH = 8;
endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the UART TX FIFO: one write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte queue feeding the UART transmitter, with
// occupancy count and a sticky overflow flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int WIDTH = UART_DATA_W,
  parameter  int DEPTH = UART_TX_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             enq_valid,
  output logic             enq_ready,
  output logic [WIDTH-1:0] deq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  input  logic             overflow_clr
);

  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic           r_overflow;
  logic           w_full;
  logic           w_empty;
  logic           w_enq_fire;
  logic           w_deq_fire;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                   (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

  assign enq_ready  = !w_full;
  assign deq_valid  = !w_empty;
  assign w_enq_fire = enq_valid && !w_full;
  assign w_deq_fire = deq_ready && !w_empty;

  assign count    = r_wr_ptr - r_rd_ptr;
  assign overflow = r_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_enq_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // A refused write sets the flag even when clear is requested the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (enq_valid && w_full) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_enq_fire),
    .i_waddr(r_wr_ptr[PTR_W-1:0]),
    .i_wdata(enq_data),
    .i_raddr(r_rd_ptr[PTR_W-1:0]),
    .o_rdata(deq_data)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued as they are
// driven and compared against the head word whenever a dequeue happens.
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] enq_data;
  logic       enq_valid;
  logic       enq_ready;
  logic [7:0] deq_data;
  logic       deq_valid;
  logic       deq_ready;
  logic [3:0] count;
  logic       overflow;
  logic       overflow_clr;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb_q[$];
  logic       exp_ov = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enq_data    (enq_data),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .deq_data    (deq_data),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .count       (count),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: apply inputs, check state, advance one clock.
  task automatic cycle(input logic ev, input logic [7:0] d, input logic dr, input logic clr);
    logic full, ef, df;
    enq_valid    = ev;
    enq_data     = d;
    deq_ready    = dr;
    overflow_clr = clr;
    #1;
    full = (sb_q.size() == DEPTH);
    chk("count", 32'(count), 32'(sb_q.size()));
    chk("enq_ready", 32'(enq_ready), 32'(!full));
    chk("deq_valid", 32'(deq_valid), 32'(sb_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(exp_ov));
    if (sb_q.size() != 0) chk("deq_data", 32'(deq_data), 32'(sb_q[0]));
    ef = ev && !full;
    df = dr && (sb_q.size() != 0);
    if (ev && full) exp_ov = 1'b1;
    else if (clr)   exp_ov = 1'b0;
    @(posedge clk);
    if (df) void'(sb_q.pop_front());
    if (ef) sb_q.push_back(d);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    enq_valid    = 1'b0;
    enq_data     = 8'h00;
    deq_ready    = 1'b0;
    overflow_clr = 1'b0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Single word, one-cycle latency, then dequeue
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h08, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Streaming with both sides active, wraps the pointers
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Full with simultaneous enqueue and dequeue: write refused
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("count_after_full_rw", 32'(count), 32'd7);

    // Clear alone
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Drain to 5 then asynchronous reset without a clock edge
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("count_before_areset", 32'(count), 32'd5);
    deq_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_deq_valid", 32'(deq_valid), 32'd0);
    chk("areset_enq_ready", 32'(enq_ready), 32'd1);
    chk("areset_overflow", 32'(overflow), 32'd0);
    sb_q.delete();
    exp_ov = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
